// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT butterfly sequencer.
// Holds the state encoding, address arithmetic and the bit-reversal helper.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
`ifdef FFT_BITREV_EN
    S_UNLOAD,
`endif
    S_DONE
  } state_e;

  // Width of the stage counter: ceil(log2(logn)), never narrower than one bit.
  function automatic int stage_w(input int logn);
    return (logn <= 2) ? 1 : $clog2(logn);
  endfunction

  localparam int FFT_LOGN    = 4;
  localparam int FFT_STAGE_W = stage_w(FFT_LOGN);

  // Distance between the two operands of a butterfly in stage s.
  function automatic int bf_span(input int logn, input int s);
    return (1 << logn) >> (s + 1);
  endfunction

  function automatic int bf_addr_a(input int logn, input int s, input int k);
    int span;
    span = bf_span(logn, s);
    return ((k >> (logn - 1 - s)) * 2 * span) + (k & (span - 1));
  endfunction

  function automatic int bf_tw(input int logn, input int s, input int k);
    return (k & (bf_span(logn, s) - 1)) << s;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_dly.sv
// Fixed-depth register delay line; an asynchronous reset empties every slot.
module fft_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] r_pipe;

  // NOTE: the delay line is reset rather than left as plain storage, so an
  // aborted transform can never leave a write strobe in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_bf_ctrl.sv
// In-place radix-2 DIF FFT sequencer: one butterfly per clock, write-back LAT later.
// Optional natural-order unload pass is enabled by defining FFT_BITREV_EN.
module fft_bf_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOGN = FFT_LOGN,
  parameter int LAT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     rd_en,
  output logic [LOGN-1:0]          rd_addr_a,
  output logic [LOGN-1:0]          rd_addr_b,
  output logic [LOGN-2:0]          tw_addr,
  output logic                     wr_en,
  output logic [LOGN-1:0]          wr_addr_a,
  output logic [LOGN-1:0]          wr_addr_b,
  output logic [stage_w(LOGN)-1:0] stage,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic [LOGN-1:0]          out_idx
);

  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;
  localparam int SW   = stage_w(LOGN);
  localparam int KW   = LOGN - 1;
  localparam int DW   = (LAT < 2) ? 1 : $clog2(LAT);
  localparam int BW   = 1 + 2 * LOGN;

  state_e          r_state;
  logic [SW-1:0]   r_s;
  logic [KW-1:0]   r_k;
  logic [DW-1:0]   r_d;
  logic            r_rd_en;
  logic [LOGN-1:0] r_rd_addr_a;
  logic [LOGN-1:0] r_rd_addr_b;
  logic [KW-1:0]   r_tw;
  logic            r_busy;
  logic            r_done;
`ifdef FFT_BITREV_EN
  logic            r_out_valid;
  logic [LOGN-1:0] r_out_idx;
`endif

  // Addresses of the butterfly that follows the current one in the same stage.
  logic [LOGN-1:0] w_nxt_a;
  logic [LOGN-1:0] w_nxt_b;
  logic [KW-1:0]   w_nxt_tw;
  logic [LOGN-1:0] w_next_span;
  logic [BW-1:0]   w_dly_in;
  logic [BW-1:0]   w_dly_out;

  assign w_nxt_a     = LOGN'(bf_addr_a(LOGN, int'(r_s), int'(r_k) + 1));
  assign w_nxt_b     = w_nxt_a + LOGN'(bf_span(LOGN, int'(r_s)));
  assign w_nxt_tw    = KW'(bf_tw(LOGN, int'(r_s), int'(r_k) + 1));
  assign w_next_span = LOGN'(bf_span(LOGN, int'(r_s) + 1));

  // NOTE: state and registered outputs use <= only, so every branch below
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_k         <= '0;
      r_d         <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef FFT_BITREV_EN
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_s         <= '0;
            r_k         <= '0;
            r_busy      <= 1'b1;
            r_rd_en     <= 1'b1;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= LOGN'(HALF);
            r_tw        <= '0;
          end
        end

        S_RUN: begin
          if (r_k == KW'(HALF - 1)) begin
            r_state     <= S_DRAIN;
            r_d         <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw        <= '0;
          end else begin
            r_k         <= r_k + KW'(1);
            r_rd_addr_a <= w_nxt_a;
            r_rd_addr_b <= w_nxt_b;
            r_tw        <= w_nxt_tw;
          end
        end

        // Holds off the next stage until the last write-back of this one lands.
        S_DRAIN: begin
          if (r_d == DW'(LAT - 1)) begin
            if (r_s == SW'(LOGN - 1)) begin
`ifdef FFT_BITREV_EN
              r_state     <= S_UNLOAD;
              r_out_valid <= 1'b1;
              r_out_idx   <= '0;
              r_rd_addr_a <= '0;
`else
              r_state     <= S_DONE;
              r_done      <= 1'b1;
`endif
            end else begin
              r_state     <= S_RUN;
              r_s         <= r_s + SW'(1);
              r_k         <= '0;
              r_rd_en     <= 1'b1;
              r_rd_addr_a <= '0;
              r_rd_addr_b <= w_next_span;
              r_tw        <= '0;
            end
          end else begin
            r_d <= r_d + DW'(1);
          end
        end

`ifdef FFT_BITREV_EN
        S_UNLOAD: begin
          if (r_out_idx == LOGN'(N - 1)) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_rd_addr_a <= '0;
          end else begin
            r_out_idx   <= r_out_idx + LOGN'(1);
            r_rd_addr_a <= LOGN'(bitrev(32'(r_out_idx) + 32'd1, LOGN));
          end
        end
`endif

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_s     <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_dly_in = {r_rd_en, r_rd_addr_a, r_rd_addr_b};

  fft_dly #(
    .W     (BW),
    .DEPTH (LAT)
  ) u_wr_dly (
    .clk   (clk),
    .reset (reset),
    .d     (w_dly_in),
    .q     (w_dly_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = w_dly_out;

  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_addr_a;
  assign rd_addr_b = r_rd_addr_b;
  assign tw_addr   = r_tw;
  assign stage     = r_s;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef FFT_BITREV_EN
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
`else
  assign out_valid = 1'b0;
  assign out_idx   = '0;
`endif

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Self-checking bench for fft_bf_ctrl: per-cycle comparison against a schedule
// model built from the stage/butterfly rules, plus hand-computed spot checks.
module tb_fft_bf_ctrl;
  import fft_ctrl_pkg::*;

  localparam int LOGN = 4;
  localparam int LAT  = 3;
  localparam int N    = 16;
  localparam int HALF = 8;
  localparam int PER  = HALF + LAT;
  localparam int SW   = stage_w(LOGN);
`ifdef FFT_BITREV_EN
  localparam int UNL      = N;
  localparam int LIT_DONE = 61;
`else
  localparam int UNL      = 0;
  localparam int LIT_DONE = 45;
`endif
  localparam int DONE_REL = 1 + LOGN * PER + UNL;
  localparam int MAXC     = 2048;

  typedef struct packed {
    logic            rd_en;
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic [LOGN-2:0] tw;
    logic            wr_en;
    logic [LOGN-1:0] wa;
    logic [LOGN-1:0] wb;
    logic [SW-1:0]   stage;
    logic            busy;
    logic            done;
    logic            ov;
    logic [LOGN-1:0] oidx;
  } obs_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic [SW-1:0]   stage;
  logic            busy;
  logic            done;
  logic            out_valid;
  logic [LOGN-1:0] out_idx;

  fft_bf_ctrl #(
    .LOGN (LOGN),
    .LAT  (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   m_free  = 0;
  obs_t exp_q [MAXC];
  obs_t act_q [MAXC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.rd_en = rd_en;     o.a     = rd_addr_a; o.b    = rd_addr_b; o.tw = tw_addr;
    o.wr_en = wr_en;     o.wa    = wr_addr_a; o.wb   = wr_addr_b;
    o.stage = stage;     o.busy  = busy;      o.done = done;
    o.ov    = out_valid; o.oidx  = out_idx;
    return o;
  endfunction

  function automatic int rev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) begin
      r = (r << 1) | (v & 1);
      v = v >> 1;
    end
    return r;
  endfunction

  // Model: lay out every cycle of a transform whose start is sampled at the end of cycle t0.
  task automatic schedule(input int t0);
    int base, done_c, span, c, av, bv;
    base   = t0 + 1;
    done_c = t0 + DONE_REL;
    for (int cc = base; cc <= done_c && cc < MAXC; cc++) begin
      exp_q[cc].busy  = 1'b1;
      exp_q[cc].stage = SW'(LOGN - 1);
    end
    for (int s = 0; s < LOGN; s++) begin
      span = N >> (s + 1);
      for (int q = 0; q < PER; q++)
        if (base + s * PER + q < MAXC) exp_q[base + s * PER + q].stage = SW'(s);
      for (int k = 0; k < HALF; k++) begin
        c  = base + s * PER + k;
        av = (k / span) * 2 * span + (k % span);
        bv = av + span;
        if (c < MAXC) begin
          exp_q[c].rd_en = 1'b1;
          exp_q[c].a     = LOGN'(av);
          exp_q[c].b     = LOGN'(bv);
          exp_q[c].tw    = (LOGN-1)'((k % span) * (1 << s));
        end
        if (c + LAT < MAXC) begin
          exp_q[c + LAT].wr_en = 1'b1;
          exp_q[c + LAT].wa    = LOGN'(av);
          exp_q[c + LAT].wb    = LOGN'(bv);
        end
      end
    end
`ifdef FFT_BITREV_EN
    for (int i = 0; i < UNL; i++) begin
      c = base + LOGN * PER + i;
      if (c < MAXC) begin
        exp_q[c].ov   = 1'b1;
        exp_q[c].oidx = LOGN'(i);
        exp_q[c].a    = LOGN'(rev(i));
      end
      if (c + LAT < MAXC) exp_q[c + LAT].wa = LOGN'(rev(i));
    end
`endif
    if (done_c < MAXC) exp_q[done_c].done = 1'b1;
    m_free = done_c + 1;
  endtask

  task automatic model_reset(input int c);
    for (int i = c + 1; i < MAXC; i++) exp_q[i] = '0;
    m_free = 0;
  endtask

  // Compare process: model accepts start on the edge, then every cycle is checked.
  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_q[i] = '0;
      act_q[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (!reset && start && cyc >= m_free) schedule(cyc);
      cyc++;
      #1;
      if (cyc < MAXC) begin
        act_q[cyc] = sample();
        check($sformatf("cycle_%0d", cyc), act_q[cyc], exp_q[cyc]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < %0d", cyc, MAXC);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int first_done(input int from, input int to);
    for (int i = from; i <= to && i < MAXC; i++) if (act_q[i].done) return i;
    return -1;
  endfunction

  int t0, t1, t2, t3, tr, target, cnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wait_cyc(3);
    #1 check("reset_outputs_zero", sample(), '0);
    reset = 1'b0;
    wait_cyc(2);

    // Transform 1: single start pulse, then spurious start pulses while busy.
    t0 = cyc;
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start = ($urandom_range(0, 3) == 0);
      wait_cyc(1);
    end
    start = 1'b0;
    wait_cyc(DONE_REL + 10);

    check("s0_first_a",  act_q[t0+1].a,  0);
    check("s0_first_b",  act_q[t0+1].b,  8);
    check("s0_first_tw", act_q[t0+1].tw, 0);
    check("s0_second_a",  act_q[t0+2].a,  1);
    check("s0_second_b",  act_q[t0+2].b,  9);
    check("s0_second_tw", act_q[t0+2].tw, 1);
    check("idle_before_busy", act_q[t0].busy, 0);
    check("first_read_en", act_q[t0+1].rd_en, 1);
    begin
      int ea [5] = '{0, 1, 2, 3, 8};
      int eb [5] = '{4, 5, 6, 7, 12};
      int et [5] = '{0, 2, 4, 6, 0};
      for (int i = 0; i < 5; i++) begin
        check($sformatf("s1_read%0d_a", i),  act_q[t0+12+i].a,  ea[i]);
        check($sformatf("s1_read%0d_b", i),  act_q[t0+12+i].b,  eb[i]);
        check($sformatf("s1_read%0d_tw", i), act_q[t0+12+i].tw, et[i]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s3_read%0d_ab", k), {act_q[t0+34+k].a, act_q[t0+34+k].b}, {4'(2*k), 4'(2*k+1)});
      check($sformatf("s3_read%0d_tw", k), act_q[t0+34+k].tw, 0);
    end
    check("wr_not_before_lat", act_q[t0+3].wr_en, 0);
    check("wr_first_en", act_q[t0+4].wr_en, 1);
    check("wr_first_addr", {act_q[t0+4].wa, act_q[t0+4].wb}, {4'd0, 4'd8});
    check("no_read_in_drain", act_q[t0+9].rd_en | act_q[t0+10].rd_en | act_q[t0+11].rd_en, 0);
    check("done_cycle", first_done(t0 + 1, t0 + DONE_REL + 8) - t0, LIT_DONE);
    cnt = 0;
    for (int i = t0 + 1; i <= t0 + DONE_REL + 8; i++) cnt += int'(act_q[i].done);
    check("done_once", cnt, 1);
    check("busy_at_done", act_q[t0+LIT_DONE].busy, 1);
    check("busy_after_done", act_q[t0+LIT_DONE+1].busy, 0);
`ifdef FFT_BITREV_EN
    begin
      int ua [4] = '{0, 8, 4, 12};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("unload%0d_idx", i), {act_q[t0+45+i].ov, act_q[t0+45+i].oidx}, {1'b1, 4'(i)});
        check($sformatf("unload%0d_a", i), act_q[t0+45+i].a, ua[i]);
        check($sformatf("unload%0d_rd_en", i), act_q[t0+45+i].rd_en, 0);
      end
    end
`endif

    // Transform 2: aborted by reset during stage 2 RUN.
    t1 = cyc;
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    target = t1 + 23 + $urandom_range(0, 7);
    while (cyc < target) wait_cyc(1);
    reset = 1'b1;
    tr = cyc;
    model_reset(tr);
    #1 check("reset_mid_run_zero", sample(), '0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(12);
    cnt = 0;
    for (int i = tr + 1; i <= tr + 14; i++) cnt += int'(act_q[i].wr_en);
    check("no_wr_after_reset", cnt, 0);

    t2 = cyc;
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(DONE_REL + 10);
    check("restart_stage0", {act_q[t2+1].rd_en, act_q[t2+1].stage, act_q[t2+1].a, act_q[t2+1].b},
          {1'b1, SW'(0), 4'd0, 4'd8});
    check("restart_done_cycle", first_done(t2 + 1, t2 + DONE_REL + 8) - t2, LIT_DONE);

    // Start held high: back-to-back transforms.
    t3 = cyc;
    start = 1'b1;
    wait_cyc(2 * DONE_REL + 10);
    start = 1'b0;
    wait_cyc(DONE_REL + 10);
    check("held_idle_gap", act_q[t3+LIT_DONE+1].busy, 0);
    check("held_second_read", {act_q[t3+LIT_DONE+2].rd_en, act_q[t3+LIT_DONE+2].a}, {1'b1, 4'd0});

    // Random start activity.
    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 15) == 0);
      wait_cyc(1);
    end
    start = 1'b0;
    wait_cyc(DONE_REL + 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
